dmem_rv32: RTL

Byte-addressable RV32 data memory for the single-cycle/pipelined core's load/store path. Supports byte, half and word stores through per-lane write enables, and sign/zero-extended loads. Read data is registered with a one-cycle valid/ready request and response handshake. After every reset, a hardware sweep clears the array to zero before the block accepts requests.

---
 rtl/dmem_rv32.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dmem_rv32.sv
// RV32 byte-addressable data memory: byte/half/word stores, sign/zero-extended loads,
// registered responses, and a zero-fill sweep after reset. Optional macro: DMEM_MISALIGN_CHK_EN.
module dmem_rv32 #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] clr_idx_reg;
    logic             busy_reg;
    logic             ready_reg;
    logic             rsp_valid_reg;
    logic [31:0]      rsp_rdata_reg;
    logic             rsp_err_reg;

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             funct3_bad;
    logic             misalign;
    logic             req_err;
    logic [3:0]       lane_mask;
    logic [3:0]       wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic [31:0]      rsp_rdata_next;
    logic             unused_addr_bits;

    assign accept           = req_valid & ready_reg;
    assign idx              = req_addr[IDX_W+1:2];
    assign off              = req_addr[1:0];
    assign unused_addr_bits = ^req_addr[ADDR_W-1:IDX_W+2];
    assign funct3_bad       = (req_funct3 == 3'b011) | (req_funct3[2] & req_funct3[1]);

`ifdef DMEM_MISALIGN_CHK_EN
    assign misalign = ((req_funct3[1:0] == 2'b01) & off[0]) |
                      ((req_funct3[1:0] == 2'b10) & (off != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = funct3_bad | misalign;

    always_comb begin
        lane_mask = 4'b0000;
        case (req_funct3[1:0])
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    // The clear sweep owns the write port until the FSM reaches IDLE.
    assign wr_idx = (state_reg == CLEAR) ? clr_idx_reg : idx;

    // Each byte lane is its own array so a partial store never needs read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_wdata;

            assign wr_en[gi] = (state_reg == CLEAR) |
                               (accept & req_we & ~req_err & lane_mask[gi]);

            always_comb begin
                lane_wdata = 8'h00;
                if (state_reg != CLEAR) begin
                    case (req_funct3[1:0])
                        2'b00:   lane_wdata = req_wdata[7:0];
                        2'b01:   lane_wdata = req_wdata[8*(gi%2) +: 8];
                        default: lane_wdata = req_wdata[8*gi +: 8];
                    endcase
                end
            end
            assign wr_data[8*gi +: 8] = lane_wdata;

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    lane_mem[wr_idx] <= wr_data[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[idx];
        end
    endgenerate

    always_comb begin
        rd_byte = rd_word[7:0];
        case (off)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'h0;
        case (req_funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'h0, rd_byte};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = 32'h0;
        endcase
    end

    assign rsp_rdata_next = (req_we | req_err) ? 32'h0 : load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= CLEAR;
            clr_idx_reg   <= '0;
            busy_reg      <= 1'b1;
            ready_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_idx_reg <= clr_idx_reg + IDX_W'(1);
                    if (clr_idx_reg == IDX_W'(DEPTH_WORDS - 1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
            rsp_valid_reg <= accept;
            if (accept) begin
                rsp_rdata_reg <= rsp_rdata_next;
                rsp_err_reg   <= req_err;
            end
        end
    end

    assign req_ready = ready_reg;
    assign busy      = busy_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
endmodule
